router_port: RTL and testbench
==============================

// Module: router_port
// PURPOSE
//  Router-side end of the byte-serial endpoint<->router link (free/put/payload).
//  Reassembles 4-byte packets sent by the endpoint into pkt_t and queues them for the router core.
//  Serializes pkt_t from the router core into 4 bytes towards the endpoint, gated by the endpoint's free.
//  Sits between router crossbar logic and one node; one instance per router port.
// PARAMETERS
//  RX_DEPTH  4  packets buffered endpoint->core (>=2)
//  TX_DEPTH  2  packets buffered core->endpoint (>=1)
// PORTS
//  clk               in   1   clock, all logic on posedge
//  rst_b             in   1   synchronous active-low reset
//  put_outbound      in   1   endpoint presents a byte on payload_outbound this cycle
//  payload_outbound  in   8   byte from endpoint
//  free_outbound     out  1   router can accept one complete packet
//  put_inbound       out  1   router presents a byte on payload_inbound this cycle
//  payload_inbound   out  8   byte to endpoint
//  free_inbound      in   1   endpoint can accept one complete packet
//  rx_pkt            out  32  head packet (pkt_t) of RX queue
//  rx_pkt_valid      out  1   RX queue non-empty
//  rx_pkt_ready      in   1   core pops rx_pkt when valid&ready
//  tx_pkt            in   32  packet (pkt_t) from core
//  tx_pkt_valid      in   1   core offers tx_pkt
//  tx_pkt_ready      out  1   TX queue not full; push on valid&ready
//  rx_proto_err      out  1   one-cycle pulse on link protocol violation
// BEHAVIOUR
//  Wire format: byte0={sourceID,destID}, byte1=data[23:16], byte2=data[15:8], byte3=data[7:0];
//   put high on 4 consecutive cycles; sender starts only when free sampled high that cycle.
//  Reset (rst_b=0 at edge): both FSMs IDLE, queues empty; free_outbound=1, put_inbound=0,
//   payload_inbound=0, rx_pkt_valid=0, tx_pkt_ready=1, rx_proto_err=0. Reset mid-packet drops it.
//  RX FSM R_IDLE->R_B1->R_B2->R_B3->R_IDLE, advancing on put_outbound=1:
//   R_IDLE+put&free_outbound: latch byte0 -> R_B1; R_B1/R_B2 latch byte1/2.
//   R_B3+put: push assembled pkt into RX queue; next cycle may be a new byte0 (back-to-back).
//   put=0 in R_B1..R_B3: discard partial, -> R_IDLE, pulse rx_proto_err.
//   put=1 in R_IDLE while free_outbound=0: byte ignored, pulse rx_proto_err.
//  free_outbound registered: 1 iff rx_count + (RX FSM not idle) + (byte0 accepted now) < RX_DEPTH,
//   evaluated on next-state values; pop this cycle counts as freeing a slot.
//  RX queue: FIFO, rx_pkt/rx_pkt_valid from head, wrap-around pointers, push+pop same cycle keeps count.
//   Latency: byte3 at edge k -> rx_pkt_valid=1 in cycle after k (if queue was empty).
//  TX queue: FIFO; tx_pkt_ready = tx_count<TX_DEPTH (pop same cycle not credited).
//  TX FSM T_IDLE->T_B0->T_B1->T_B2->T_B3: leave T_IDLE when queue non-empty and free_inbound=1;
//   put_inbound/payload_inbound registered, put_inbound=1 exactly in T_B0..T_B3;
//   free_inbound ignored once started; pop queue at T_B3; T_B3->T_B0 directly if another
//   packet queued and free_inbound=1 during T_B3, else T_IDLE.
//   Latency: push at edge k into empty idle TX with free_inbound=1 -> byte0 visible in cycle k+2.
//  RX and TX paths fully independent; simultaneous activity in both directions is legal.
// TESTING
//  1 Endpoint sends 0x12,0xAB,0xCD,0xEF with put 4 cycles -> rx_pkt=32'h12ABCDEF, srcID=1, destID=2, valid next cycle.
//  2 rx_pkt_ready=0, RX_DEPTH=4: send 4 packets back-to-back -> free_outbound=0 after 4th byte0; 5th put ignored, rx_proto_err=1; pop one -> free_outbound=1.
//  3 put drops after byte1 -> rx_proto_err pulse, nothing queued, next full packet received intact.
//  4 Core pushes 32'h34000001 then 32'h35FFFFFF, free_inbound=1 -> put_inbound 8 consecutive cycles, bytes 34,00,00,01,35,FF,FF,FF.
//  5 free_inbound=0 with TX queued -> put_inbound stays 0; raise free_inbound -> byte0 next cycle; dropping it mid-packet does not stall.
//  6 rst_b=0 during R_B2 and T_B1 -> all outputs at reset values next cycle, partial packets lost, queues empty.

Source files
------------

// File: rtl/router_port_if.sv
// Packet type and link bundle for the router port.
// Carries the byte-serial endpoint link and the core packet handshakes.
package router_pkg;
  typedef struct packed {
    logic [3:0]  src_id;
    logic [3:0]  dest_id;
    logic [23:0] data;
  } pkt_t;
endpackage

interface router_port_if;
  import router_pkg::*;
  logic       put_outbound;
  logic [7:0] payload_outbound;
  logic       free_outbound;
  logic       put_inbound;
  logic [7:0] payload_inbound;
  logic       free_inbound;
  pkt_t       rx_pkt;
  logic       rx_pkt_valid;
  logic       rx_pkt_ready;
  pkt_t       tx_pkt;
  logic       tx_pkt_valid;
  logic       tx_pkt_ready;
  logic       rx_proto_err;

  modport master (
    output put_outbound, payload_outbound, free_inbound,
    output rx_pkt_ready, tx_pkt, tx_pkt_valid,
    input  free_outbound, put_inbound, payload_inbound,
    input  rx_pkt, rx_pkt_valid, tx_pkt_ready, rx_proto_err
  );

  modport slave (
    input  put_outbound, payload_outbound, free_inbound,
    input  rx_pkt_ready, tx_pkt, tx_pkt_valid,
    output free_outbound, put_inbound, payload_inbound,
    output rx_pkt, rx_pkt_valid, tx_pkt_ready, rx_proto_err
  );
endinterface

// File: rtl/router_port.sv
// Router-side end of the byte-serial endpoint link.
// Reassembles RX packets into a FIFO, serializes TX FIFO packets.
module router_port
  import router_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  router_port_if.slave lnk
);

  localparam int RAW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int TAW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int RCW = $clog2(RX_DEPTH + 1);
  localparam int TCW = $clog2(TX_DEPTH + 1);

  typedef enum logic [1:0] {
    R_IDLE, R_B1, R_B2, R_B3
  } rx_st_t;

  typedef enum logic [2:0] {
    T_IDLE, T_B0, T_B1, T_B2, T_B3
  } tx_st_t;

  function automatic logic [RAW-1:0] rinc(
    input logic [RAW-1:0] p
  );
    return (p == RAW'(RX_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [TAW-1:0] tinc(
    input logic [TAW-1:0] p
  );
    return (p == TAW'(TX_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  rx_st_t         r_st, r_nxt;
  logic [7:0]     b0, b1, b2;
  pkt_t           rx_mem [RX_DEPTH];
  logic [RAW-1:0] r_rd, r_wr;
  logic [RCW-1:0] r_cnt, r_cnt_nxt;
  logic [RCW:0]   r_occ;
  logic           free_r, err_r;
  logic           acc0, r_push, r_pop, r_err;

  always_comb begin
    acc0   = (r_st == R_IDLE) && lnk.put_outbound && free_r;
    r_push = (r_st == R_B3) && lnk.put_outbound;
    r_pop  = (r_cnt != '0) && lnk.rx_pkt_ready;
    r_err  = (r_st == R_IDLE) ?
             (lnk.put_outbound && !free_r) :
             !lnk.put_outbound;
    r_nxt  = R_IDLE;
    unique case (r_st)
      R_IDLE: if (acc0) r_nxt = R_B1;
      R_B1:   if (lnk.put_outbound) r_nxt = R_B2;
      R_B2:   if (lnk.put_outbound) r_nxt = R_B3;
      default: r_nxt = R_IDLE;
    endcase
    r_cnt_nxt = r_cnt + RCW'(r_push) - RCW'(r_pop);
    // an in-flight packet reserves its slot so the push can't overflow
    r_occ = {1'b0, r_cnt_nxt} + (RCW+1)'(r_nxt != R_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_st   <= R_IDLE;
      b0     <= '0;
      b1     <= '0;
      b2     <= '0;
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      free_r <= 1'b1;
      err_r  <= 1'b0;
    end else begin
      r_st   <= r_nxt;
      r_cnt  <= r_cnt_nxt;
      free_r <= r_occ < (RCW+1)'(RX_DEPTH);
      err_r  <= r_err;
      if (acc0) b0 <= lnk.payload_outbound;
      if ((r_st == R_B1) && lnk.put_outbound)
        b1 <= lnk.payload_outbound;
      if ((r_st == R_B2) && lnk.put_outbound)
        b2 <= lnk.payload_outbound;
      if (r_push) r_wr <= rinc(r_wr);
      if (r_pop) r_rd <= rinc(r_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (r_push)
      rx_mem[r_wr] <= {b0, b1, b2, lnk.payload_outbound};
  end

  assign lnk.rx_pkt        = rx_mem[r_rd];
  assign lnk.rx_pkt_valid  = (r_cnt != '0);
  assign lnk.free_outbound = free_r;
  assign lnk.rx_proto_err  = err_r;

  tx_st_t         t_st, t_nxt;
  pkt_t           tx_mem [TX_DEPTH];
  pkt_t           hd;
  logic [TAW-1:0] t_rd, t_wr, t_hd;
  logic [TCW-1:0] t_cnt;
  logic           t_push, t_pop;
  logic           put_r;
  logic [7:0]     pay_r, pay_nxt;

  always_comb begin
    t_push = lnk.tx_pkt_valid && (t_cnt < TCW'(TX_DEPTH));
    t_pop  = (t_st == T_B3);
    t_nxt  = T_IDLE;
    unique case (t_st)
      T_IDLE:
        if ((t_cnt != '0) && lnk.free_inbound) t_nxt = T_B0;
      T_B0: t_nxt = T_B1;
      T_B1: t_nxt = T_B2;
      T_B2: t_nxt = T_B3;
      default:
        if ((t_cnt > TCW'(1)) && lnk.free_inbound) t_nxt = T_B0;
    endcase
    // byte for the next state comes from the entry behind the one leaving
    t_hd    = t_pop ? tinc(t_rd) : t_rd;
    hd      = tx_mem[t_hd];
    pay_nxt = '0;
    unique case (1'b1)
      (t_nxt == T_B0): pay_nxt = {hd.src_id, hd.dest_id};
      (t_nxt == T_B1): pay_nxt = hd.data[23:16];
      (t_nxt == T_B2): pay_nxt = hd.data[15:8];
      (t_nxt == T_B3): pay_nxt = hd.data[7:0];
      default:         pay_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      t_st  <= T_IDLE;
      t_rd  <= '0;
      t_wr  <= '0;
      t_cnt <= '0;
      put_r <= 1'b0;
      pay_r <= '0;
    end else begin
      t_st  <= t_nxt;
      t_cnt <= t_cnt + TCW'(t_push) - TCW'(t_pop);
      put_r <= (t_nxt != T_IDLE);
      pay_r <= pay_nxt;
      if (t_push) t_wr <= tinc(t_wr);
      if (t_pop) t_rd <= tinc(t_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (t_push) tx_mem[t_wr] <= lnk.tx_pkt;
  end

  assign lnk.tx_pkt_ready    = (t_cnt < TCW'(TX_DEPTH));
  assign lnk.put_inbound     = put_r;
  assign lnk.payload_inbound = pay_r;

endmodule

// File: tb/tb_router_port.sv
// Bench for router_port: vector tables plus scoreboard queues
// for RX packets and TX bytes, with hand-written corner sequences.
module tb_router_port;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  router_port_if lnk ();

  router_port #(
    .RX_DEPTH(4),
    .TX_DEPTH(2)
  ) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .lnk  (lnk)
  );

  typedef struct {
    logic [7:0]  b [4];
    logic [31:0] exp;
  } rx_vec_t;

  typedef struct {
    logic [31:0] pkt;
    logic [7:0]  b [4];
  } tx_vec_t;

  rx_vec_t     rx_tab [8];
  tx_vec_t     tx_tab [4];
  logic [31:0] rx_exp [$];
  logic [7:0]  tx_exp [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_rx(input int i, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic [31:0] e);
    rx_tab[i].b[0] = a;
    rx_tab[i].b[1] = b;
    rx_tab[i].b[2] = c;
    rx_tab[i].b[3] = d;
    rx_tab[i].exp  = e;
  endtask

  task automatic set_tx(input int i, input logic [31:0] p,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    tx_tab[i].pkt  = p;
    tx_tab[i].b[0] = a;
    tx_tab[i].b[1] = b;
    tx_tab[i].b[2] = c;
    tx_tab[i].b[3] = d;
  endtask

  always @(negedge clk) begin
    if (rst_b && lnk.rx_pkt_valid && lnk.rx_pkt_ready) begin
      if (rx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_extra got %h want none", lnk.rx_pkt);
      end else begin
        chk("rx_pkt", lnk.rx_pkt, rx_exp.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (lnk.put_inbound) begin
      if (tx_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_extra got %h want none",
                 lnk.payload_inbound);
      end else begin
        chk("tx_byte", {24'h0, lnk.payload_inbound},
            {24'h0, tx_exp.pop_front()});
      end
    end
  end

  task automatic put_byte(input logic [7:0] b);
    lnk.put_outbound     = 1'b1;
    lnk.payload_outbound = b;
    @(posedge clk); #1;
    lnk.put_outbound     = 1'b0;
  endtask

  task automatic wait_free();
    int n = 0;
    while (!lnk.free_outbound && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!lnk.free_outbound)
      chk("free_timeout", {31'h0, lnk.free_outbound}, 32'h1);
  endtask

  task automatic send_rx(input int i);
    wait_free();
    rx_exp.push_back(rx_tab[i].exp);
    for (int j = 0; j < 4; j++) put_byte(rx_tab[i].b[j]);
  endtask

  task automatic push_tx(input int i, input int nexp);
    int n = 0;
    lnk.tx_pkt       = tx_tab[i].pkt;
    lnk.tx_pkt_valid = 1'b1;
    while (!lnk.tx_pkt_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!lnk.tx_pkt_ready)
      chk("tx_ready_timeout", {31'h0, lnk.tx_pkt_ready}, 32'h1);
    for (int j = 0; j < nexp; j++) tx_exp.push_back(tx_tab[i].b[j]);
    @(posedge clk); #1;
    lnk.tx_pkt_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rx_exp.size() != 0 || tx_exp.size() != 0 ||
            lnk.put_inbound || lnk.rx_pkt_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rx_sb_empty", rx_exp.size(), 0);
    chk("tx_sb_empty", tx_exp.size(), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_free_out"}, {31'h0, lnk.free_outbound}, 32'h1);
    chk({tag, "_put_in"}, {31'h0, lnk.put_inbound}, 32'h0);
    chk({tag, "_pay_in"}, {24'h0, lnk.payload_inbound}, 32'h0);
    chk({tag, "_rx_valid"}, {31'h0, lnk.rx_pkt_valid}, 32'h0);
    chk({tag, "_tx_ready"}, {31'h0, lnk.tx_pkt_ready}, 32'h1);
    chk({tag, "_proto_err"}, {31'h0, lnk.rx_proto_err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_rx(0, 8'h12, 8'hAB, 8'hCD, 8'hEF, 32'h12ABCDEF);
    set_rx(1, 8'hF0, 8'h00, 8'h00, 8'h00, 32'hF0000000);
    set_rx(2, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 32'h0FFFFFFF);
    set_rx(3, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 32'hA55AA55A);
    set_rx(4, 8'h31, 8'h01, 8'h02, 8'h03, 32'h31010203);
    set_rx(5, 8'h42, 8'h10, 8'h20, 8'h30, 32'h42102030);
    set_rx(6, 8'h53, 8'h77, 8'h88, 8'h99, 32'h53778899);
    set_rx(7, 8'h64, 8'hDE, 8'hAD, 8'hBE, 32'h64DEADBE);
    set_tx(0, 32'h34000001, 8'h34, 8'h00, 8'h00, 8'h01);
    set_tx(1, 32'h35FFFFFF, 8'h35, 8'hFF, 8'hFF, 8'hFF);
    set_tx(2, 32'h5A123456, 8'h5A, 8'h12, 8'h34, 8'h56);
    set_tx(3, 32'h9C0F0F0F, 8'h9C, 8'h0F, 8'h0F, 8'h0F);

    lnk.put_outbound     = 1'b0;
    lnk.payload_outbound = '0;
    lnk.free_inbound     = 1'b1;
    lnk.rx_pkt_ready     = 1'b0;
    lnk.tx_pkt           = '0;
    lnk.tx_pkt_valid     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst_b = 1'b1;
    @(posedge clk); #1;

    // single packet, latency and field split
    send_rx(0);
    chk("rx_valid_latency", {31'h0, lnk.rx_pkt_valid}, 32'h1);
    chk("rx_head", lnk.rx_pkt, 32'h12ABCDEF);
    chk("rx_src", {28'h0, lnk.rx_pkt.src_id}, 32'h1);
    chk("rx_dest", {28'h0, lnk.rx_pkt.dest_id}, 32'h2);
    lnk.rx_pkt_ready = 1'b1;

    for (int i = 1; i < 4; i++) send_rx(i);
    wait_drain();

    // broken packet after byte1
    put_byte(8'h56);
    put_byte(8'h78);
    @(posedge clk); #1;
    chk("err_drop_mid", {31'h0, lnk.rx_proto_err}, 32'h1);
    chk("no_partial", {31'h0, lnk.rx_pkt_valid}, 32'h0);
    @(posedge clk); #1;
    chk("err_pulse_end", {31'h0, lnk.rx_proto_err}, 32'h0);
    send_rx(4);
    wait_drain();

    // fill the RX queue with the core stalled
    lnk.rx_pkt_ready = 1'b0;
    for (int i = 4; i < 7; i++) send_rx(i);
    rx_exp.push_back(rx_tab[7].exp);
    put_byte(rx_tab[7].b[0]);
    chk("free_after_4th_b0", {31'h0, lnk.free_outbound}, 32'h0);
    for (int j = 1; j < 4; j++) put_byte(rx_tab[7].b[j]);
    chk("free_when_full", {31'h0, lnk.free_outbound}, 32'h0);
    put_byte(8'h99);
    chk("err_put_full", {31'h0, lnk.rx_proto_err}, 32'h1);
    lnk.rx_pkt_ready = 1'b1;
    @(posedge clk); #1;
    lnk.rx_pkt_ready = 1'b0;
    chk("free_after_pop", {31'h0, lnk.free_outbound}, 32'h1);
    chk("err_cleared", {31'h0, lnk.rx_proto_err}, 32'h0);
    lnk.rx_pkt_ready = 1'b1;
    wait_drain();

    // two TX packets back to back
    push_tx(0, 4);
    chk("tx_ready_one", {31'h0, lnk.tx_pkt_ready}, 32'h1);
    push_tx(1, 4);
    for (int i = 0; i < 8; i++) begin
      chk("tx_put_run", {31'h0, lnk.put_inbound}, 32'h1);
      @(posedge clk); #1;
    end
    chk("tx_put_end", {31'h0, lnk.put_inbound}, 32'h0);
    wait_drain();

    // endpoint not free, then free only for the start
    lnk.free_inbound = 1'b0;
    push_tx(2, 4);
    for (int i = 0; i < 3; i++) begin
      chk("tx_held", {31'h0, lnk.put_inbound}, 32'h0);
      @(posedge clk); #1;
    end
    lnk.free_inbound = 1'b1;
    @(posedge clk); #1;
    chk("tx_start_on_free", {31'h0, lnk.put_inbound}, 32'h1);
    chk("tx_start_byte", {24'h0, lnk.payload_inbound}, 32'h5A);
    lnk.free_inbound = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("tx_no_stall", {31'h0, lnk.put_inbound}, 32'h1);
    end
    @(posedge clk); #1;
    chk("tx_done", {31'h0, lnk.put_inbound}, 32'h0);
    lnk.free_inbound = 1'b1;
    wait_drain();

    // reset during RX byte2 wait and TX byte1
    lnk.rx_pkt_ready = 1'b0;
    push_tx(3, 2);
    put_byte(8'hE1);
    put_byte(8'hE2);
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("midrst");
    rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_tx_idle", {31'h0, lnk.put_inbound}, 32'h0);
      chk("post_rst_rx_empty", {31'h0, lnk.rx_pkt_valid}, 32'h0);
    end
    lnk.rx_pkt_ready = 1'b1;
    send_rx(2);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
